// File: rtl/wbc_pkg.sv
// Shared types and sizing helpers for the Wishbone classic arbiter/router.
package wbc_pkg;

  // Two-state arbitration FSM encoding
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_OWNED = 1'b1;

  // Width of an index able to address n items (never narrower than one bit)
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wbcdecoder.sv
// Upper-address slave decoder; on duplicate match values the lowest index wins.
module wbcdecoder #(
  parameter int                      NS        = 8,
  parameter int                      MUXWIDTH  = 3,
  parameter logic [NS*MUXWIDTH-1:0]  SLAVE_MUX = '0
) (
  input  logic [MUXWIDTH-1:0] addr_hi,
  output logic [NS-1:0]       sel,
  output logic                hit
);

  // one-hot select of the lowest slave whose match value equals addr_hi
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int s = 0; s < NS; s++) begin
      if (!hit && (addr_hi == SLAVE_MUX[s*MUXWIDTH +: MUXWIDTH])) begin
        sel[s] = 1'b1;
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wbcrr_arbiter.sv
// Round-robin request selector: first requester at or after ptr, wrapping.
module wbcrr_arbiter
  import wbc_pkg::*;
#(
  parameter int NM = 4,
  parameter int IW = idx_w(NM)
) (
  input  logic [NM-1:0] req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          valid
);

  // scan NM positions starting at ptr, keep the first one that requests
  always_comb begin
    int k;
    k     = 0;
    grant = '0;
    valid = 1'b0;
    for (int i = 0; i < NM; i++) begin
      k = (int'(ptr) + i) % NM;
      if (!valid && req[k]) begin
        valid = 1'b1;
        grant = IW'(k);
      end
    end
  end

endmodule

// File: rtl/wbcarbrouter.sv
// NM-master / NS-slave Wishbone classic arbiter and address router.
// Optional stalled-strobe watchdog enabled by defining WBCARBROUTER_TIMEOUT_EN.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | no owner; arbiter picks a requester, ownership starts next cycle
//   ST_OWNED | grant holds the bus until its cyc drops
module wbcarbrouter
  import wbc_pkg::*;
#(
  parameter int                     NM        = 4,
  parameter int                     NS        = 8,
  parameter int                     AW        = 32,
  parameter int                     DW        = 32,
  parameter int                     MUXWIDTH  = 3,
  parameter logic [NS*MUXWIDTH-1:0] SLAVE_MUX = {3'd7, 3'd6, 3'd5, 3'd4,
                                                 3'd3, 3'd2, 3'd1, 3'd0},
  parameter int                     TIMEOUT   = 255,
  localparam int                    SW        = DW / 8,
  localparam int                    SAW       = AW - MUXWIDTH
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [NM-1:0]    i_mcyc,
  input  logic [NM-1:0]    i_mstb,
  input  logic [NM-1:0]    i_mwe,
  input  logic [NM*AW-1:0] i_maddr,
  input  logic [NM*DW-1:0] i_mdata,
  input  logic [NM*SW-1:0] i_msel,
  output logic [NM-1:0]    o_mack,
  output logic [NM*DW-1:0] o_mdata,
  output logic [NM-1:0]    o_merr,
  output logic [NS-1:0]     o_scyc,
  output logic [NS-1:0]     o_sstb,
  output logic [NS-1:0]     o_swe,
  output logic [NS*SAW-1:0] o_saddr,
  output logic [NS*DW-1:0]  o_sdata,
  output logic [NS*SW-1:0]  o_ssel,
  input  logic [NS-1:0]     i_sack,
  input  logic [NS*DW-1:0]  i_sdata,
  input  logic [NS-1:0]     i_serr
);

  localparam int IW = idx_w(NM);

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("wbcarbrouter: TIMEOUT must be at least 1");
  end

  state_t        state;
  logic [IW-1:0] grant;
  logic [IW-1:0] ptr;
  logic [IW-1:0] arb_grant;
  logic          arb_valid;
  logic          owned;

  logic          gcyc, gstb, gwe;
  logic [AW-1:0] gaddr;
  logic [DW-1:0] gdata;
  logic [SW-1:0] gsel;

  logic [NS-1:0] dsel;
  logic          dhit;

  logic          rack, rerr;
  logic [DW-1:0] rdata;
  logic          route;

  logic          err_pulse;
  logic          to_hit;

  assign owned = (state == ST_OWNED);

  wbcrr_arbiter #(.NM(NM), .IW(IW)) u_arb (
    .req   (i_mcyc),
    .ptr   (ptr),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  // select the granted master's request signals
  always_comb begin
    gcyc  = 1'b0;
    gstb  = 1'b0;
    gwe   = 1'b0;
    gaddr = '0;
    gdata = '0;
    gsel  = '0;
    for (int m = 0; m < NM; m++) begin
      if (grant == IW'(m)) begin
        gcyc  = i_mcyc[m];
        gstb  = i_mstb[m];
        gwe   = i_mwe[m];
        gaddr = i_maddr[m*AW +: AW];
        gdata = i_mdata[m*DW +: DW];
        gsel  = i_msel[m*SW +: SW];
      end
    end
  end

  wbcdecoder #(.NS(NS), .MUXWIDTH(MUXWIDTH), .SLAVE_MUX(SLAVE_MUX)) u_dec (
    .addr_hi (gaddr[AW-1 -: MUXWIDTH]),
    .sel     (dsel),
    .hit     (dhit)
  );

  // forward the owner's request to the decoded slave only
  always_comb begin
    o_scyc  = '0;
    o_sstb  = '0;
    o_swe   = '0;
    o_saddr = '0;
    o_sdata = '0;
    o_ssel  = '0;
    for (int s = 0; s < NS; s++) begin
      if (owned && dsel[s]) begin
        o_scyc[s]               = gcyc;
        o_sstb[s]               = gstb & ~to_hit;
        o_swe[s]                = gwe;
        o_saddr[s*SAW +: SAW]   = gaddr[SAW-1:0];
        o_sdata[s*DW +: DW]     = gdata;
        o_ssel[s*SW +: SW]      = gsel;
      end
    end
  end

  // pick the decoded slave's response
  always_comb begin
    rack  = 1'b0;
    rerr  = 1'b0;
    rdata = '0;
    for (int s = 0; s < NS; s++) begin
      if (dsel[s]) begin
        rack  = i_sack[s];
        rerr  = i_serr[s];
        rdata = i_sdata[s*DW +: DW];
      end
    end
  end

  assign route = owned & gcyc & dhit;

  // return path reaches the granted master only
  always_comb begin
    o_mack  = '0;
    o_merr  = '0;
    o_mdata = '0;
    for (int m = 0; m < NM; m++) begin
      if (grant == IW'(m)) begin
        o_mack[m]           = route & rack;
        o_merr[m]           = (route & rerr) | err_pulse | to_hit;
        o_mdata[m*DW +: DW] = route ? rdata : '0;
      end
    end
  end

  // arbitration FSM with round-robin pointer advanced on release
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= ST_IDLE;
      grant <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            state <= ST_OWNED;
            grant <= arb_grant;
          end
        end
        ST_OWNED: begin
          if (!gcyc) begin
            state <= ST_IDLE;
            ptr   <= (grant == IW'(NM-1)) ? '0 : grant + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // single-cycle bus error when the owner strobes an unmapped address
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= owned & gcyc & gstb & ~dhit & ~err_pulse;
    end
  end

`ifdef WBCARBROUTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] to_cnt;

  assign to_hit = owned && (to_cnt == CW'(TIMEOUT));

  // count strobe cycles left unanswered; expiry errors the owner once
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      to_cnt <= '0;
    end else if (to_hit) begin
      to_cnt <= '0;
    end else if (owned && gcyc && gstb && !rack && !rerr && !err_pulse) begin
      to_cnt <= to_cnt + 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

endmodule

// File: tb/tb_wbcarbrouter.sv
// Bench for wbcarbrouter: instance A uses the identity slave map, instance B
// maps slaves 6 and 7 both to 3'b110 (no slave at 3'b111) with TIMEOUT=8.
module tb_wbcarbrouter;

  localparam int NM = 4;
  localparam int NS = 8;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MUXWIDTH = 3;
  localparam int SW = DW / 8;
  localparam int SAW = AW - MUXWIDTH;
  localparam logic [NS*MUXWIDTH-1:0] MUX_B = {3'd6, 3'd6, 3'd5, 3'd4,
                                              3'd3, 3'd2, 3'd1, 3'd0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic use_b = 1'b0;

  logic [NM-1:0]    mcyc, mstb, mwe;
  logic [NM*AW-1:0] maddr;
  logic [NM*DW-1:0] mdata;
  logic [NM*SW-1:0] msel;
  logic [NS-1:0]    sack, serr;
  logic [NS*DW-1:0] sdata;

  logic [NM-1:0]    a_mack, a_merr, b_mack, b_merr;
  logic [NM*DW-1:0] a_mdata, b_mdata;
  logic [NS-1:0]    a_scyc, a_sstb, a_swe, b_scyc, b_sstb, b_swe;
  logic [NS*SAW-1:0] a_saddr, b_saddr;
  logic [NS*DW-1:0] a_sdata, b_sdata;
  logic [NS*SW-1:0] a_ssel, b_ssel;

  logic [NM-1:0]    o_mack, o_merr;
  logic [NM*DW-1:0] o_mdata;
  logic [NS-1:0]    o_scyc, o_sstb, o_swe;
  logic [NS*SAW-1:0] o_saddr;
  logic [NS*DW-1:0] o_sdata;
  logic [NS*SW-1:0] o_ssel;
  logic nz_a, nz_b;

  assign o_mack  = use_b ? b_mack  : a_mack;
  assign o_merr  = use_b ? b_merr  : a_merr;
  assign o_mdata = use_b ? b_mdata : a_mdata;
  assign o_scyc  = use_b ? b_scyc  : a_scyc;
  assign o_sstb  = use_b ? b_sstb  : a_sstb;
  assign o_swe   = use_b ? b_swe   : a_swe;
  assign o_saddr = use_b ? b_saddr : a_saddr;
  assign o_sdata = use_b ? b_sdata : a_sdata;
  assign o_ssel  = use_b ? b_ssel  : a_ssel;
  assign nz_a = |{a_mack, a_merr, a_mdata, a_scyc, a_sstb, a_swe, a_saddr, a_sdata, a_ssel};
  assign nz_b = |{b_mack, b_merr, b_mdata, b_scyc, b_sstb, b_swe, b_saddr, b_sdata, b_ssel};

  wbcarbrouter u_dut_a (
    .i_clk(clk), .i_reset(rst),
    .i_mcyc(mcyc), .i_mstb(mstb), .i_mwe(mwe), .i_maddr(maddr), .i_mdata(mdata), .i_msel(msel),
    .o_mack(a_mack), .o_mdata(a_mdata), .o_merr(a_merr),
    .o_scyc(a_scyc), .o_sstb(a_sstb), .o_swe(a_swe), .o_saddr(a_saddr), .o_sdata(a_sdata), .o_ssel(a_ssel),
    .i_sack(sack), .i_sdata(sdata), .i_serr(serr)
  );

  wbcarbrouter #(.SLAVE_MUX(MUX_B), .TIMEOUT(8)) u_dut_b (
    .i_clk(clk), .i_reset(rst),
    .i_mcyc(mcyc), .i_mstb(mstb), .i_mwe(mwe), .i_maddr(maddr), .i_mdata(mdata), .i_msel(msel),
    .o_mack(b_mack), .o_mdata(b_mdata), .o_merr(b_merr),
    .o_scyc(b_scyc), .o_sstb(b_sstb), .o_swe(b_swe), .o_saddr(b_saddr), .o_sdata(b_sdata), .o_ssel(b_ssel),
    .i_sack(sack), .i_sdata(sdata), .i_serr(serr)
  );

  typedef struct {
    bit             on_b;
    int             master;
    logic [AW-1:0]  addr;
    logic           we;
    logic [DW-1:0]  wdata;
    logic [SW-1:0]  sel;
    logic [DW-1:0]  rdata;
    int             slave;
  } vec_t;

  typedef struct {
    int             master;
    int             slave;
    logic [SAW-1:0] saddr;
    logic           we;
    logic [DW-1:0]  wdata;
    logic [SW-1:0]  sel;
    logic [DW-1:0]  rdata;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];
  int   order_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic int onehot_idx(input logic [NS-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NS; i++) if (v[i] && r < 0) r = i;
    return r;
  endfunction

  function automatic logic [AW-1:0] tag_addr(input int m);
    return {3'(m), 29'h100 + 29'(m)};
  endfunction

  task automatic set_master(input int m, input logic cyc, input logic stb, input logic we,
                            input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    mcyc[m] = cyc;
    mstb[m] = stb;
    mwe[m]  = we;
    maddr[m*AW +: AW] = a;
    mdata[m*DW +: DW] = d;
    msel[m*SW +: SW]  = s;
  endtask

  task automatic idle_all();
    mcyc = '0; mstb = '0; mwe = '0; maddr = '0; mdata = '0; msel = '0;
    sack = '0; serr = '0; sdata = '0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  // one single-beat transaction; slave responds the cycle after it sees stb
  task automatic run_txn(input vec_t v, input string tag);
    exp_t e, got;
    int lat, s;
    logic [NM*DW-1:0] others;
    use_b = v.on_b;
    e.master = v.master; e.slave = v.slave; e.saddr = v.addr[SAW-1:0];
    e.we = v.we; e.wdata = v.wdata; e.sel = v.sel; e.rdata = v.rdata;
    set_master(v.master, 1'b1, 1'b1, v.we, v.addr, v.wdata, v.sel);
    sb.push_back(e);
    lat = -1;
    for (int c = 0; c < 8; c++) begin
      settle();
      if (|o_scyc) begin
        lat = c;
        break;
      end
      next_cycle();
    end
    got = sb.pop_front();
    check($sformatf("%s latency", tag), 64'(lat), 64'(1));
    if (lat >= 0) begin
      s = onehot_idx(o_scyc);
      check($sformatf("%s slave", tag), 64'(s), 64'(got.slave));
      check($sformatf("%s sstb", tag), 64'(o_sstb), 64'(1) << got.slave);
      check($sformatf("%s saddr", tag), 64'(o_saddr[s*SAW +: SAW]), 64'(got.saddr));
      check($sformatf("%s swe", tag), 64'(o_swe[s]), 64'(got.we));
      check($sformatf("%s sdata", tag), 64'(o_sdata[s*DW +: DW]), 64'(got.wdata));
      check($sformatf("%s ssel", tag), 64'(o_ssel[s*SW +: SW]), 64'(got.sel));
      check($sformatf("%s early ack", tag), 64'(o_mack), 64'(0));
      next_cycle();
      sack[got.slave] = 1'b1;
      sdata[got.slave*DW +: DW] = got.rdata;
      settle();
      check($sformatf("%s mack", tag), 64'(o_mack), 64'(1) << got.master);
      check($sformatf("%s mdata", tag), 64'(o_mdata[got.master*DW +: DW]), 64'(got.rdata));
      others = o_mdata;
      others[got.master*DW +: DW] = '0;
      check($sformatf("%s other mdata", tag), 64'(|others), 64'(0));
    end
    next_cycle();
    set_master(v.master, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    sack = '0;
    sdata = '0;
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int g, s, expg;

    vecs[0] = '{1'b0, 1, 32'h4000_0010, 1'b1, 32'h1234_5678, 4'hF, 32'h0000_0000, 2};
    vecs[1] = '{1'b0, 0, 32'h0000_0004, 1'b0, 32'h0000_0000, 4'hF, 32'hCAFE_0001, 0};
    vecs[2] = '{1'b0, 3, 32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF, 7};
    vecs[3] = '{1'b0, 2, 32'h2ABC_DEF0, 1'b1, 32'h5555_AAAA, 4'h3, 32'h0000_0000, 1};
    vecs[4] = '{1'b0, 1, 32'hA000_0100, 1'b0, 32'h0000_0000, 4'hF, 32'h0BAD_F00D, 5};
    vecs[5] = '{1'b1, 0, 32'hC000_0040, 1'b0, 32'h0000_0000, 4'hF, 32'h1357_9BDF, 6};
    vecs[6] = '{1'b1, 2, 32'h6000_0020, 1'b1, 32'h0F0F_F0F0, 4'h8, 32'h0000_0000, 3};

    // reset state
    do_reset();
    settle();
    check("reset outputs A", 64'(nz_a), 64'(0));
    check("reset outputs B", 64'(nz_b), 64'(0));

    // single-master transactions, including duplicate-map priority on B
    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // masters 0 and 2 together from reset
    do_reset();
    use_b = 1'b0;
    set_master(0, 1'b1, 1'b1, 1'b0, tag_addr(0), '0, 4'hF);
    set_master(2, 1'b1, 1'b1, 1'b0, tag_addr(2), '0, 4'hF);
    settle();
    check("pair request cycle", 64'(o_scyc), 64'(0));
    next_cycle(); settle();
    check("pair first grant", 64'(o_scyc), 64'(1));
    check("pair first saddr", 64'(o_saddr[0 +: SAW]), 64'(29'h100));
    next_cycle();
    set_master(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    settle();
    check("pair release", 64'(o_scyc), 64'(0));
    next_cycle(); settle();
    check("pair dead cycle", 64'(o_scyc), 64'(0));
    check("pair ptr", 64'(u_dut_a.ptr), 64'(1));
    next_cycle(); settle();
    check("pair second grant", 64'(o_scyc), 64'(4));
    check("pair second saddr", 64'(o_saddr[2*SAW +: SAW]), 64'(29'h102));
    next_cycle(); idle_all(); next_cycle(); next_cycle();

    // all four masters keep requesting: strict rotation
    do_reset();
    for (int m = 0; m < NM; m++) set_master(m, 1'b1, 1'b1, 1'b0, tag_addr(m), '0, 4'hF);
    order_q = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      g = -1;
      for (int c = 0; c < 6; c++) begin
        settle();
        if (|o_scyc) begin
          s = onehot_idx(o_scyc);
          g = int'(o_saddr[s*SAW +: SAW]) - 32'h100;
          break;
        end
        next_cycle();
      end
      expg = order_q.pop_front();
      check($sformatf("rr grant %0d", k), 64'(g), 64'(expg));
      next_cycle();
      if (g >= 0 && g < NM) begin
        mcyc[g] = 1'b0; mstb[g] = 1'b0;
        next_cycle();
        mcyc[g] = 1'b1; mstb[g] = 1'b1;
      end
    end
    idle_all(); next_cycle(); next_cycle(); next_cycle();

    // unmapped address on B: no strobe, one-cycle error
    use_b = 1'b1;
    set_master(0, 1'b1, 1'b1, 1'b0, 32'hE000_0000, '0, 4'hF);
    settle();
    check("miss request cycle merr", 64'(o_merr), 64'(0));
    next_cycle(); settle();
    check("miss sstb", 64'(o_sstb), 64'(0));
    check("miss scyc", 64'(o_scyc), 64'(0));
    check("miss merr early", 64'(o_merr), 64'(0));
    next_cycle(); settle();
    check("miss merr pulse", 64'(o_merr), 64'(1));
    next_cycle();
    set_master(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    settle();
    check("miss merr end", 64'(o_merr), 64'(0));
    next_cycle(); next_cycle();

    // reset during an owned read, pointer left nonzero beforehand
    use_b = 1'b0;
    set_master(3, 1'b1, 1'b1, 1'b0, tag_addr(3), '0, 4'hF);
    next_cycle(); settle();
    check("abort owned", 64'(o_scyc), 64'(8));
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    sack[3] = 1'b1;
    sdata[3*DW +: DW] = 32'hFFFF_0000;
    set_master(0, 1'b1, 1'b1, 1'b0, tag_addr(0), '0, 4'hF);
    settle();
    check("abort outputs A", 64'(nz_a), 64'(0));
    check("abort outputs B", 64'(nz_b), 64'(0));
    next_cycle(); settle();
    check("abort regrant", 64'(o_scyc), 64'(1));
    check("abort regrant saddr", 64'(o_saddr[0 +: SAW]), 64'(29'h100));
    idle_all(); next_cycle(); next_cycle(); next_cycle();

`ifdef WBCARBROUTER_TIMEOUT_EN
    // B with TIMEOUT=8, slave 1 never answers
    begin
      logic stall_ok;
      use_b = 1'b1;
      stall_ok = 1'b1;
      set_master(0, 1'b1, 1'b1, 1'b1, 32'h2000_0000, 32'h1111_2222, 4'hF);
      for (int c = 1; c <= 8; c++) begin
        next_cycle(); settle();
        if (o_merr !== '0 || o_sstb !== 8'h02) stall_ok = 1'b0;
      end
      check("timeout stall window", 64'(stall_ok), 64'(1));
      next_cycle(); settle();
      check("timeout merr", 64'(o_merr), 64'(1));
      check("timeout sstb", 64'(o_sstb), 64'(0));
      next_cycle();
      set_master(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      settle();
      check("timeout counter", 64'(u_dut_b.to_cnt), 64'(0));
      check("timeout merr end", 64'(o_merr), 64'(0));
      next_cycle(); next_cycle();
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
